// File: rtl/gcd_stein_emu_pkg.sv
// Shared types and constants for the binary-GCD bus accelerator.
// Register offsets are relative to the block's BASE address.
package gcd_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FACTOR,
    ST_ALIGN,
    ST_STEP,
    ST_DONE
  } state_t;

  localparam logic [15:0] OFF_A1  = 16'h0000;
  localparam logic [15:0] OFF_A2  = 16'h0004;
  localparam logic [15:0] OFF_W   = 16'h0008;
  localparam logic [15:0] OFF_S   = 16'h000C;
  localparam logic [15:0] OFF_CYC = 16'h0010;
  localparam logic [15:0] OFF_GIN = 16'h0014;

  localparam int S_DONE = 0;
  localparam int S_ERR  = 1;
  localparam int S_OVR  = 2;
  localparam int S_BUSY = 3;
  localparam int S_ABT  = 4;

  function automatic int kw_of(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_stein_emu_if.sv
// Emulated SoC register bus: address, read/write strobes and data.
// The CPU side is the master; the peripheral is the slave.
interface gcd_stein_emu_if;

  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;

  modport master (
    output saddress,
    output srd,
    output swr,
    output sdata_in,
    input  sdata_out
  );

  modport slave (
    input  saddress,
    input  srd,
    input  swr,
    input  sdata_in,
    output sdata_out
  );

endinterface

// File: rtl/gcd_stein_core.sv
// Binary (Stein) GCD engine: FSM plus a/b/k datapath.
// One state per cycle; the result register holds until the next success.
module gcd_stein_core
  import gcd_emu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result
);

  localparam int KW = kw_of(WIDTH);

  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_a, w_a_nx;
  logic [WIDTH-1:0] r_b, w_b_nx;
  logic [WIDTH-1:0] r_w, w_w_nx;
  logic [KW-1:0]    r_k, w_k_nx;
  logic             r_err, w_err_nx;
  logic [WIDTH-1:0] w_a_sub_b;
  logic [WIDTH-1:0] w_b_sub_a;

  assign w_a_sub_b = r_a - r_b;
  assign w_b_sub_a = r_b - r_a;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_w     <= '0;
      r_k     <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_w     <= w_w_nx;
      r_k     <= w_k_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_w_nx     = r_w;
    w_k_nx     = r_k;
    w_err_nx   = r_err;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_err_nx   = 1'b0;
          w_state_nx = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_a_nx = i_op_a;
        w_b_nx = i_op_b;
        w_k_nx = '0;
        if (i_op_a == '0 && i_op_b == '0) begin
          w_err_nx   = 1'b1;
          w_state_nx = ST_DONE;
        end else if (i_op_a == '0) begin
          w_a_nx     = i_op_b;
          w_state_nx = ST_DONE;
        end else if (i_op_b == '0) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_FACTOR;
        end
      end
      ST_FACTOR: begin
        if (!r_a[0] && !r_b[0]) begin
          w_a_nx = r_a >> 1;
          w_b_nx = r_b >> 1;
          w_k_nx = r_k + 1'b1;
        end else begin
          w_state_nx = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (!r_a[0]) begin
          w_a_nx = r_a >> 1;
        end else begin
          w_state_nx = ST_STEP;
        end
      end
      ST_STEP: begin
        if (!r_b[0]) begin
          w_b_nx = r_b >> 1;
        end else if (r_a > r_b) begin
          w_a_nx = r_b;
          w_b_nx = w_a_sub_b;
        end else begin
          w_b_nx = w_b_sub_a;
          if (w_b_sub_a == '0) begin
            w_state_nx = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (!r_err) begin
          w_w_nx = r_a << r_k;
        end
        w_state_nx = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
    // completion in the same cycle beats an abort request
    if (i_abort && r_state != ST_IDLE
        && r_state != ST_DONE) begin
      w_state_nx = ST_IDLE;
    end
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_done   = (r_state == ST_DONE);
  assign o_err    = r_err;
  assign o_result = r_w;

endmodule

// File: rtl/gcd_stein_emu.sv
// Bus-attached GCD accelerator: register decode, status, cycle counter,
// GPIO input latch and completion counter around the Stein GCD core.
module gcd_stein_emu
  import gcd_emu_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter logic [15:0] BASE  = 16'h00D8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  gcd_stein_emu_if.slave        bus,
  input  logic [31:0]           gpio_in,
  input  logic                  gpio_latch,
  output logic [31:0]           gpio_out,
  output logic [31:0]           gpio_in_s_insp
);

  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_a2;
  logic             r_ovr;
  logic             r_abt;
  logic             r_done;
  logic [31:0]      r_cyc;
  logic [31:0]      r_gin;
  logic [7:0]       r_cnt;
  logic [31:0]      r_rdata;

  logic             w_busy;
  logic             w_cdone;
  logic             w_err;
  logic [WIDTH-1:0] w_res;

  logic w_sel_a1, w_sel_a2, w_sel_w;
  logic w_sel_s, w_sel_cyc, w_sel_gin;
  logic w_wr_a1, w_wr_a2, w_wr_s;
  logic w_start, w_abort;
  logic [31:0] w_stat;
  logic [31:0] w_rd;

  assign w_sel_a1  = bus.saddress == (BASE + OFF_A1);
  assign w_sel_a2  = bus.saddress == (BASE + OFF_A2);
  assign w_sel_w   = bus.saddress == (BASE + OFF_W);
  assign w_sel_s   = bus.saddress == (BASE + OFF_S);
  assign w_sel_cyc = bus.saddress == (BASE + OFF_CYC);
  assign w_sel_gin = bus.saddress == (BASE + OFF_GIN);

  assign w_wr_a1 = bus.swr && w_sel_a1;
  assign w_wr_a2 = bus.swr && w_sel_a2;
  assign w_wr_s  = bus.swr && w_sel_s;
  assign w_start = w_wr_a2 && !w_busy;
  assign w_abort = w_wr_s && bus.sdata_in[0] && w_busy;

  gcd_stein_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .n_reset  (n_reset),
    .i_start  (w_start),
    .i_abort  (w_abort),
    .i_op_a   (r_a1),
    .i_op_b   (r_a2),
    .o_busy   (w_busy),
    .o_done   (w_cdone),
    .o_err    (w_err),
    .o_result (w_res)
  );

  always_comb begin
    w_stat         = '0;
    w_stat[S_DONE] = r_done;
    w_stat[S_ERR]  = w_err;
    w_stat[S_OVR]  = r_ovr;
    w_stat[S_BUSY] = w_busy;
    w_stat[S_ABT]  = r_abt;
  end

  always_comb begin
    w_rd = '0;
    unique case (1'b1)
      w_sel_a1:  w_rd[WIDTH-1:0] = r_a1;
      w_sel_a2:  w_rd[WIDTH-1:0] = r_a2;
      w_sel_w:   w_rd[WIDTH-1:0] = w_res;
      w_sel_s:   w_rd = w_stat;
      w_sel_cyc: w_rd = r_cyc;
      w_sel_gin: w_rd = r_gin;
      default:   w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1    <= '0;
      r_a2    <= '0;
      r_ovr   <= 1'b0;
      r_abt   <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= '0;
      r_gin   <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_wr_a1 && !w_busy) begin
        r_a1 <= bus.sdata_in[WIDTH-1:0];
      end
      if (w_start) begin
        r_a2 <= bus.sdata_in[WIDTH-1:0];
      end
      if (w_start) begin
        r_ovr <= 1'b0;
      end else if ((w_wr_a1 || w_wr_a2) && w_busy) begin
        r_ovr <= 1'b1;
      end
      if (w_start) begin
        r_done <= 1'b0;
      end else if (w_cdone) begin
        r_done <= 1'b1;
      end
      if (w_start) begin
        r_abt <= 1'b0;
      end else if (w_abort && !w_cdone) begin
        r_abt <= 1'b1;
      end
      if (w_start) begin
        r_cyc <= '0;
      end else if (w_busy && r_cyc != '1) begin
        r_cyc <= r_cyc + 32'd1;
      end
      if (w_cdone) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (gpio_latch) begin
        r_gin <= gpio_in;
      end
      // read data reflects pre-write state of the same edge
      if (bus.srd) begin
        r_rdata <= w_rd;
      end
    end
  end

  assign bus.sdata_out   = r_rdata;
  assign gpio_out        = {24'h0, r_cnt};
  assign gpio_in_s_insp  = r_gin;

endmodule

// File: tb/tb_gcd_stein_emu.sv
// Directed bench for gcd_stein_emu: plain-arithmetic GCD model,
// per-cycle GPIO compare and hand-computed literal checks.
module tb_gcd_stein_emu;
  import gcd_emu_pkg::*;

  localparam int          WIDTH = 32;
  localparam logic [15:0] BASE  = 16'h00D8;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  gcd_stein_emu_if bus_if();

  gcd_stein_emu #(.WIDTH(WIDTH), .BASE(BASE)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .bus            (bus_if),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_w = '0;
  logic [7:0]  m_cnt = '0;
  logic [31:0] m_gin = '0;
  bit          cmp_en = 1'b0;

  function automatic logic [31:0] gcd_ref(
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (n_reset) begin
      chk("gin_insp", gpio_in_s_insp, m_gin);
      if (cmp_en) chk("gpio_out", gpio_out, {24'h0, m_cnt});
    end
  end

  task automatic wr(input logic [15:0] off, input logic [31:0] d);
    @(negedge clk);
    bus_if.swr      = 1'b1;
    bus_if.saddress = BASE + off;
    bus_if.sdata_in = d;
    @(posedge clk);
    #1 bus_if.swr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, output logic [31:0] d);
    @(negedge clk);
    bus_if.srd      = 1'b1;
    bus_if.saddress = BASE + off;
    @(posedge clk);
    #1 bus_if.srd = 1'b0;
    d = bus_if.sdata_out;
  endtask

  task automatic rdwr(input logic [15:0] off, input logic [31:0] d,
                      output logic [31:0] q);
    @(negedge clk);
    bus_if.srd      = 1'b1;
    bus_if.swr      = 1'b1;
    bus_if.saddress = BASE + off;
    bus_if.sdata_in = d;
    @(posedge clk);
    #1;
    bus_if.srd = 1'b0;
    bus_if.swr = 1'b0;
    q = bus_if.sdata_out;
  endtask

  task automatic latch(input logic [31:0] v);
    @(negedge clk);
    gpio_in    = v;
    gpio_latch = 1'b1;
    @(posedge clk);
    #1 gpio_latch = 1'b0;
    m_gin = v;
  endtask

  task automatic wait_done(output logic [31:0] s, output int n);
    n = 0;
    do begin
      n++;
      rd(OFF_S, s);
    end while (s[S_BUSY] && n < 400);
    if (s[S_BUSY]) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got busy after %0d polls, need idle", n);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int n, output logic [31:0] cyc);
    logic [31:0] s, r, exp_s;
    cmp_en = 1'b0;
    wr(OFF_A1, a);
    wr(OFF_A2, b);
    wait_done(s, n);
    if (a == 0 && b == 0) begin
      exp_s = 32'h03;
    end else begin
      exp_s = 32'h01;
      m_w   = gcd_ref(a, b);
    end
    m_cnt++;
    chk("op_status", s, exp_s);
    rd(OFF_W, r);
    chk("op_result", r, m_w);
    rd(OFF_CYC, cyc);
    chk("op_cyc_bound", 32'(cyc <= 4 * WIDTH + 3), 32'd1);
    cmp_en = 1'b1;
  endtask

  logic [31:0] va [6] = '{32'd0, 32'd48, 32'd0, 32'd1071, 32'd7, 32'd64};
  logic [31:0] vb [6] = '{32'd35, 32'd0, 32'd0, 32'd462, 32'd13, 32'd256};
  logic [31:0] ve [6] = '{32'd35, 32'd48, 32'd48, 32'd21, 32'd1, 32'd64};
  logic [15:0] offs [6] = '{OFF_A1, OFF_A2, OFF_W, OFF_S, OFF_CYC, OFF_GIN};

  initial begin
    logic [31:0] r, cyc;
    int n;
    bus_if.saddress = '0;
    bus_if.srd      = 1'b0;
    bus_if.swr      = 1'b0;
    bus_if.sdata_in = '0;
    repeat (3) @(posedge clk);
    #1 n_reset = 1'b1;

    foreach (offs[i]) begin
      rd(offs[i], r);
      chk("reset_reg", r, 32'h0);
    end
    chk("reset_gpio_out", gpio_out, 32'h0);
    cmp_en = 1'b1;

    run_op(32'd48, 32'd18, n, cyc);
    chk("busy_clear_edge", 32'(n - 1), 32'd11);
    chk("cyc_48_18", cyc, 32'd11);
    rd(OFF_W, r);
    chk("w_48_18", r, 32'd6);
    chk("gpio_out_1", gpio_out, 32'd1);

    foreach (va[i]) begin
      run_op(va[i], vb[i], n, cyc);
      rd(OFF_W, r);
      chk("vec_w_lit", r, ve[i]);
    end

    cmp_en = 1'b0;
    wr(OFF_A1, 32'hFFFF_FFFF);
    wr(OFF_A2, 32'd1);
    wr(OFF_A2, 32'd5);
    wr(OFF_A1, 32'd9);
    wait_done(r, n);
    m_w = gcd_ref(32'hFFFF_FFFF, 32'd1);
    m_cnt++;
    chk("ovr_status", r, 32'h05);
    rd(OFF_W, r);
    chk("ovr_w", r, 32'd1);
    rd(OFF_CYC, r);
    chk("ovr_cyc", r, 32'd67);
    rd(OFF_A2, r);
    chk("ovr_a2_kept", r, 32'd1);
    rd(OFF_A1, r);
    chk("ovr_a1_kept", r, 32'hFFFF_FFFF);
    cmp_en = 1'b1;

    wr(OFF_A1, 32'd1024);
    wr(OFF_A2, 32'd768);
    repeat (2) @(posedge clk);
    wr(OFF_S, 32'd1);
    rd(OFF_S, r);
    chk("abort_status", r, 32'h10);
    rd(OFF_W, r);
    chk("abort_w_kept", r, m_w);
    run_op(32'd1024, 32'd768, n, cyc);
    rd(OFF_W, r);
    chk("w_1024_768", r, 32'd256);
    wr(OFF_S, 32'd1);
    rd(OFF_S, r);
    chk("abort_idle", r, 32'h01);

    rdwr(OFF_A1, 32'd7, r);
    chk("rdwr_old", r, 32'd1024);
    rd(OFF_A1, r);
    chk("rdwr_new", r, 32'd7);
    repeat (3) @(posedge clk);
    #1 chk("rd_hold", bus_if.sdata_out, 32'd7);
    rd(16'h0018, r);
    chk("unmapped_hi", r, 32'h0);
    rd(16'hFFFC, r);
    chk("unmapped_lo", r, 32'h0);

    latch(32'hA5A5_1234);
    rd(OFF_GIN, r);
    chk("gin_latch", r, 32'hA5A5_1234);
    wr(OFF_GIN, 32'h0000_FFFF);
    @(negedge clk) gpio_in = 32'h1111_1111;
    rd(OFF_GIN, r);
    chk("gin_no_write", r, 32'hA5A5_1234);

    for (int i = 0; i < 300 && m_cnt != 0; i++) begin
      run_op(32'd0, 32'd1, n, cyc);
    end
    chk("gpio_out_wrap", gpio_out, 32'h0);

    run_op(32'd5, 32'd0, n, cyc);
    wr(OFF_A1, 32'hFFFF_FFFF);
    wr(OFF_A2, 32'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp_en  = 1'b0;
    n_reset = 1'b0;
    #1;
    chk("rst_sdata_out", bus_if.sdata_out, 32'h0);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gin", gpio_in_s_insp, 32'h0);
    m_cnt = '0;
    m_gin = '0;
    m_w   = '0;
    @(negedge clk) n_reset = 1'b1;
    foreach (offs[i]) begin
      rd(offs[i], r);
      chk("rst_reg", r, 32'h0);
    end
    cmp_en = 1'b1;
    run_op(32'd48, 32'd18, n, cyc);
    chk("post_rst_cyc", cyc, 32'd11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
